sfifo_rd_stream: RTL

- Read-side stage directly downstream of a standard (non-FWFT) synchronous FIFO and its fill/flag tracker.
- Issues the FIFO read strobe from the registered empty flag, captures read data one cycle after each strobe into a 2-entry holding buffer, and presents it as a valid/ready stream.
- Sustains one word per clock, never reads while empty, and supports a synchronous flush.

---
 rtl/sfifo_rd_stream_if.sv | 33 +++
 rtl/sfifo_rd_stream.sv | 92 +++++++++
 2 files changed

// File: rtl/sfifo_rd_stream_if.sv
// Bundle of FIFO read-port and outgoing valid/ready stream signals for sfifo_rd_stream.
// The slave modport is the stage's view; master is the view of whatever drives the FIFO and sinks the stream.
interface sfifo_rd_stream_if #(
    parameter int G_DATAWIDTH = 32
);
    logic                   fifo_empty;
    logic                   fifo_underflow;
    logic                   fifo_rd_en;
    logic [G_DATAWIDTH-1:0] fifo_rd_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [G_DATAWIDTH-1:0] m_data;

    modport slave (
        input  fifo_empty,
        input  fifo_underflow,
        input  fifo_rd_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport master (
        output fifo_empty,
        output fifo_underflow,
        output fifo_rd_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/sfifo_rd_stream.sv
// Read stage behind a non-FWFT synchronous FIFO: issues reads from the registered empty flag,
// captures returning data into a 2-entry holding buffer and presents it as a valid/ready stream.
module sfifo_rd_stream #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_RDLAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sfifo_rd_stream_if.slave      bus,
    input  logic                  flush,
    output logic [1:0]            occupancy,
    output logic                  err_underflow
);

    generate
        if (G_RDLAT != 1) begin : g_bad_rdlat
            $error("sfifo_rd_stream supports only G_RDLAT = 1");
        end
    endgenerate

    logic [1:0]             count_q, count_d;
    logic                   inflight_q, inflight_d;
    logic                   drop_pend_q, drop_pend_d;
    logic                   err_q, err_d;
    logic [G_DATAWIDTH-1:0] head_q, head_d;
    logic [G_DATAWIDTH-1:0] tail_q, tail_d;

    logic                   pop;
    logic                   capture;
    logic                   rd_en;
    logic [2:0]             demand;
    logic [1:0]             count_after_pop;
    logic [2:0]             count_next;

    always_comb begin
        pop             = (count_q != 2'd0) & bus.m_ready;
        capture         = inflight_q & ~drop_pend_q;

        // Words held plus the one already requested, less the one leaving now; pop implies count >= 1.
        demand          = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en           = ~rst & ~bus.fifo_empty & ~flush & (demand <= 3'd1);

        count_after_pop = count_q - {1'b0, pop};
        count_next      = {1'b0, count_after_pop} + {2'b00, capture};

        head_d = head_q;
        tail_d = tail_q;
        if (pop && (count_q == 2'd2)) begin
            head_d = tail_q;
        end
        if (capture) begin
            if (count_after_pop == 2'd0) begin
                head_d = bus.fifo_rd_data;
            end else begin
                tail_d = bus.fifo_rd_data;
            end
        end

        count_d     = flush ? 2'd0 : count_next[1:0];
        inflight_d  = rd_en;
        drop_pend_d = flush & inflight_q;
        err_d       = err_q | (bus.fifo_underflow & inflight_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            drop_pend_q <= 1'b0;
            err_q       <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            drop_pend_q <= drop_pend_d;
            err_q       <= err_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (count_q != 2'd0);
    assign bus.m_data     = head_q;
    assign occupancy      = count_q;
    assign err_underflow  = err_q;

    // Read issue is throttled on count + inflight, so the buffer can never be asked to hold a third word.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) count_next <= 3'd2);

endmodule
